regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Owns the single write port of the 32x64 register file and shares it between two writeback requesters
//  (req0: ALU writeback, req1: load/memory writeback) with valid/ready handshakes and round-robin priority.
//  Also sequences a zeroing sweep of x1..x31 after reset and on demand, so the datapath starts from a known state.
//  Sits between the datapath writeback sources and the register file's din/Rw/WE inputs; x0 is never written.
// PARAMETERS
//  DATA_W  64  width of write data
//  ADDR_W  5   width of register address
//  NREGS   32  number of architectural registers (index 0 is hard zero)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  clr_start   in   1       request a zeroing sweep (sampled only in RUN)
//  clr_busy    out  1       1 while sweep in progress; requesters are stalled
//  req0_valid  in   1       ALU writeback request
//  req0_addr   in   ADDR_W  destination register
//  req0_data   in   DATA_W  write value
//  req0_ready  out  1       request 0 accepted this cycle
//  req1_valid  in   1       load writeback request
//  req1_addr   in   ADDR_W  destination register
//  req1_data   in   DATA_W  write value
//  req1_ready  out  1       request 1 accepted this cycle
//  rf_we       out  1       register file write enable (registered)
//  rf_waddr    out  ADDR_W  register file write address (registered)
//  rf_wdata    out  DATA_W  register file write data (registered)
//  x0_drop     out  1       1-cycle pulse: an accepted request targeted x0 and was discarded
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=CLEAR, sweep_ptr=1, last_grant=1, rf_we=0, rf_waddr=0, rf_wdata=0,
//    x0_drop=0; clr_busy=1, req0_ready=req1_ready=0 (combinational from state).
//  - FSM states: CLEAR, RUN. CLEAR->RUN after the write of address NREGS-1 is issued. RUN->CLEAR when
//    clr_start=1 at a clock edge; that cycle's handshake (if any) still completes. clr_start in CLEAR ignored.
//  - CLEAR: each cycle registers rf_we=1, rf_waddr=sweep_ptr, rf_wdata=0, sweep_ptr++; NREGS-1 (=31) writes,
//    addresses 1..31 in order, no gaps. sweep_ptr reloads to 1 on leaving CLEAR. Readys held 0.
//  - RUN arbitration (combinational): only req0 valid -> grant 0; only req1 -> grant 1; both -> grant the
//    one not equal to last_grant. reqN_ready = (state==RUN) & grant==N & reqN_valid. At most one ready per cycle.
//  - Transfer = valid & ready at a rising edge. last_grant updates to the winner only on a transfer.
//  - Latency: transfer at edge N -> rf_we/rf_waddr/rf_wdata valid for cycle after edge N, deasserted at
//    edge N+1 unless another transfer occurs. Back-to-back transfers give rf_we=1 every cycle.
//  - x0: transfer with addr==0 is accepted (ready=1) but registers rf_we=0 and x0_drop=1 for one cycle.
//  - Requester rules: valid held with stable addr/data until ready; loser keeps waiting, never dropped.
//  - Both requesters same address: one write per cycle in grant order; the later-granted value persists.
//  - Reset mid-sweep or mid-transfer: outputs drop immediately, sweep restarts from 1 after rst_n rises.
//  - Widths: addresses >= NREGS impossible at defaults (ADDR_W=5, NREGS=32); no arithmetic on data.
// TESTING
//  - Reset release -> clr_busy=1 for 31 cycles, rf_we=1 with rf_waddr 1..31 and rf_wdata=0, then RUN, readys live.
//  - RUN, req0 {addr=5,data=0xA5} alone -> req0_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xA5.
//  - Both valid continuously (req0 addr 3, req1 addr 4) -> grants alternate 0,1,0,1; rf_we=1 every cycle.
//  - req1 {addr=0,data=0xFF} -> req1_ready=1, next cycle rf_we=0, x0_drop=1 for exactly one cycle.
//  - clr_start pulse while req0 valid -> current transfer written, then 31-cycle sweep with readys=0;
//    req0 held and granted on first RUN cycle.
//  - rst_n low at sweep_ptr=17 -> rf_we=0 asynchronously; after release sweep restarts at address 1.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the two writeback sources, the sweep controls and the register file write port.
`timescale 1ns/1ps
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              clr_start;
    logic              clr_busy;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              x0_drop;

    modport master (
        output clr_start, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  clr_busy, req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, x0_drop
    );

    modport slave (
        input  clr_start, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output clr_busy, req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, x0_drop
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register file write port; zeroes x1..x31 after reset and on request.
`timescale 1ns/1ps
module regfile_wr_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NREGS - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] sweep_ptr_r;
    logic              last_grant_r;
    logic              grant_s;
    logic              ready0_s;
    logic              ready1_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] xfer_addr_s;
    logic [DATA_W-1:0] xfer_data_s;
    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;
    logic              x0_drop_r;

    // Round-robin grant, handshake readys and the winning request's payload
    always_comb begin
        grant_s     = last_grant_r;
        ready0_s    = 1'b0;
        ready1_s    = 1'b0;
        xfer_addr_s = bus.req0_addr;
        xfer_data_s = bus.req0_data;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (state_r == ST_RUN) begin
            ready0_s = bus.req0_valid && (grant_s == 1'b0);
            ready1_s = bus.req1_valid && (grant_s == 1'b1);
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
        if (ready1_s) begin
            xfer_addr_s = bus.req1_addr;
            xfer_data_s = bus.req1_data;
        end else begin
            xfer_addr_s = bus.req0_addr;
            xfer_data_s = bus.req0_data;
        end
        xfer_s = ready0_s | ready1_s;
    end

    // Next-state logic: a running handshake still completes on the clr_start edge
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (sweep_ptr_r == LAST_ADDR) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.clr_start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_CLEAR;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write-port pipeline stage: sweep writes in CLEAR, accepted requests in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_ptr_r  <= FIRST_ADDR;
            last_grant_r <= 1'b1;
            rf_we_r      <= 1'b0;
            rf_waddr_r   <= {ADDR_W{1'b0}};
            rf_wdata_r   <= {DATA_W{1'b0}};
            x0_drop_r    <= 1'b0;
        end else if (state_r == ST_CLEAR) begin
            rf_we_r     <= 1'b1;
            rf_waddr_r  <= sweep_ptr_r;
            rf_wdata_r  <= {DATA_W{1'b0}};
            x0_drop_r   <= 1'b0;
            sweep_ptr_r <= (sweep_ptr_r == LAST_ADDR) ? FIRST_ADDR : sweep_ptr_r + ADDR_W'(1);
        end else begin
            sweep_ptr_r <= FIRST_ADDR;
            if (xfer_s) begin
                last_grant_r <= ready1_s;
                // x0 is hard zero: accept the request but suppress the write
                if (xfer_addr_s == {ADDR_W{1'b0}}) begin
                    rf_we_r   <= 1'b0;
                    x0_drop_r <= 1'b1;
                end else begin
                    rf_we_r    <= 1'b1;
                    rf_waddr_r <= xfer_addr_s;
                    rf_wdata_r <= xfer_data_s;
                    x0_drop_r  <= 1'b0;
                end
            end else begin
                rf_we_r   <= 1'b0;
                x0_drop_r <= 1'b0;
            end
        end
    end

    assign bus.clr_busy   = (state_r == ST_CLEAR);
    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rf_we      = rf_we_r;
    assign bus.rf_waddr   = rf_waddr_r;
    assign bus.rf_wdata   = rf_wdata_r;
    assign bus.x0_drop    = x0_drop_r;
endmodule
